inter_rr_arbiter: RTL and testbench

INTER_RR_ARBITER -- requirements
Module: inter_rr_arbiter

---
 rtl/inter_pkg.sv | 18 +
 rtl/inter_fifo.sv | 67 ++++++
 rtl/inter_rr_arbiter.sv | 102 ++++++++++
 tb/tb_inter_rr_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/inter_pkg.sv
// Shared types for the two-master round-robin arbiter: FSM states, packet layout, default sizes.
// Packet layout is {dest, addr[2:0], value[2:0]}; dest selects slave 2 when set.
package inter_pkg;
  localparam int PKT_W_DEF      = 7;
  localparam int FIFO_DEPTH_DEF = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_e;

  typedef struct packed {
    logic       dest;
    logic [2:0] addr;
    logic [2:0] value;
  } pkt_t;
endpackage

// File: rtl/inter_fifo.sv
// Per-master request queue: power-of-two ring buffer, push/pop at the edge, head valid when !empty.
// Zero-latency head; full is derived from registered occupancy, so a same-edge pop never frees a slot.
module inter_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] CNT_MAX = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full    = (cnt_q == CNT_MAX);
  assign empty   = (cnt_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: pointers and occupancy define what is live.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule

// File: rtl/inter_rr_arbiter.sv
// Two-master round-robin arbiter routing queued packets to slave 1 or 2 by the dest bit.
// Push to valid takes two edges; a stalled slave holds ISSUE indefinitely, and full queues drop via in_ready.
module inter_rr_arbiter
  import inter_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int PKT_W      = PKT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_1,
  input  logic             in_valid_2,
  input  logic [PKT_W-1:0] data_in_1,
  input  logic [PKT_W-1:0] data_in_2,
  output logic             in_ready_1,
  output logic             in_ready_2,
  input  logic             ready_slave1,
  input  logic             ready_slave2,
  output logic             valid_slave1,
  output logic             valid_slave2,
  output logic [2:0]       addr_out,
  output logic [2:0]       value_out,
  output logic             handshake_slave1,
  output logic             handshake_slave2,
  output logic             grant_id
);
  state_e           state_q, state_d;
  pkt_t             pkt_q, pkt_d;
  logic             last_grant_q, last_grant_d;
  logic             grant_id_q, grant_id_d;
  logic [PKT_W-1:0] head_1, head_2;
  logic             full_1, full_2, empty_1, empty_2;
  logic             push_1, push_2, pop_1, pop_2;
  logic             sel_ready, winner;

  assign in_ready_1 = !full_1;
  assign in_ready_2 = !full_2;
  assign push_1     = in_valid_1 && in_ready_1;
  assign push_2     = in_valid_2 && in_ready_2;

  // Only the slave addressed by the issued packet can complete it.
  assign sel_ready = pkt_q.dest ? ready_slave2 : ready_slave1;
  assign pop_1     = (state_q == ISSUE) && sel_ready && !grant_id_q;
  assign pop_2     = (state_q == ISSUE) && sel_ready && grant_id_q;

  inter_fifo #(.DEPTH(FIFO_DEPTH), .W(PKT_W)) u_fifo_1 (
    .clk(clk), .rst(rst), .push(push_1), .pop(pop_1), .din(data_in_1),
    .head(head_1), .full(full_1), .empty(empty_1)
  );

  inter_fifo #(.DEPTH(FIFO_DEPTH), .W(PKT_W)) u_fifo_2 (
    .clk(clk), .rst(rst), .push(push_2), .pop(pop_2), .din(data_in_2),
    .head(head_2), .full(full_2), .empty(empty_2)
  );

  always_comb begin
    state_d      = state_q;
    pkt_d        = pkt_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    winner       = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty_1 || !empty_2) begin
          // On a tie the master not granted last wins; otherwise the lone requester.
          winner       = (!empty_1 && !empty_2) ? !last_grant_q : empty_1;
          grant_id_d   = winner;
          last_grant_d = winner;
          pkt_d        = winner ? pkt_t'(head_2) : pkt_t'(head_1);
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        if (sel_ready) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pkt_q        <= '0;
      last_grant_q <= 1'b1;
      grant_id_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pkt_q        <= pkt_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
    end
  end

  assign valid_slave1     = (state_q == ISSUE) && !pkt_q.dest;
  assign valid_slave2     = (state_q == ISSUE) && pkt_q.dest;
  assign addr_out         = (state_q == ISSUE) ? pkt_q.addr : 3'd0;
  assign value_out        = (state_q == ISSUE) ? pkt_q.value : 3'd0;
  assign handshake_slave1 = (state_q == DONE) && !pkt_q.dest;
  assign handshake_slave2 = (state_q == DONE) && pkt_q.dest;
  assign grant_id         = grant_id_q;
endmodule

// File: tb/tb_inter_rr_arbiter.sv
// Bench for inter_rr_arbiter: transaction-level queue model compared every cycle, plus literal directed checks.
module tb_inter_rr_arbiter;
  localparam int DEPTH = 2;

  logic       clk, rst;
  logic       in_valid_1, in_valid_2;
  logic [6:0] data_in_1, data_in_2;
  logic       in_ready_1, in_ready_2;
  logic       ready_slave1, ready_slave2;
  logic       valid_slave1, valid_slave2;
  logic [2:0] addr_out, value_out;
  logic       handshake_slave1, handshake_slave2;
  logic       grant_id;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 0;

  inter_rr_arbiter #(.FIFO_DEPTH(DEPTH), .PKT_W(7)) dut (
    .clk(clk), .rst(rst),
    .in_valid_1(in_valid_1), .in_valid_2(in_valid_2),
    .data_in_1(data_in_1), .data_in_2(data_in_2),
    .in_ready_1(in_ready_1), .in_ready_2(in_ready_2),
    .ready_slave1(ready_slave1), .ready_slave2(ready_slave2),
    .valid_slave1(valid_slave1), .valid_slave2(valid_slave2),
    .addr_out(addr_out), .value_out(value_out),
    .handshake_slave1(handshake_slave1), .handshake_slave2(handshake_slave2),
    .grant_id(grant_id)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: per-master packet queues plus the transfer currently offered to a slave.
  bit [6:0] mq1[$];
  bit [6:0] mq2[$];
  int       m_phase;   // 0 nothing offered, 1 offered to slave, 2 just completed
  bit       m_owner;
  bit       m_last;
  bit [6:0] m_pkt;
  bit       m_p1, m_p2;

  always @(posedge clk) begin
    if (rst) begin
      mq1.delete();
      mq2.delete();
      m_phase = 0;
      m_owner = 0;
      m_last  = 1;
      m_pkt   = '0;
    end else begin
      m_p1 = in_valid_1 && (mq1.size() < DEPTH);
      m_p2 = in_valid_2 && (mq2.size() < DEPTH);
      if (m_phase == 0) begin
        if (mq1.size() > 0 || mq2.size() > 0) begin
          if (mq1.size() > 0 && mq2.size() > 0) m_owner = !m_last;
          else m_owner = (mq2.size() > 0);
          m_last  = m_owner;
          m_pkt   = m_owner ? mq2[0] : mq1[0];
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (m_pkt[6] ? ready_slave2 : ready_slave1) begin
          if (m_owner) void'(mq2.pop_front());
          else void'(mq1.pop_front());
          m_phase = 2;
        end
      end else begin
        m_phase = 0;
      end
      if (m_p1) mq1.push_back(data_in_1);
      if (m_p2) mq2.push_back(data_in_2);
    end
  end

  logic [12:0] exp_vec, act_vec;
  always @(negedge clk) begin
    if (chk_en) begin
      act_vec = {in_ready_1, in_ready_2, valid_slave1, valid_slave2, addr_out, value_out,
                 handshake_slave1, handshake_slave2, grant_id};
      exp_vec = {mq1.size() < DEPTH, mq2.size() < DEPTH,
                 m_phase == 1 && !m_pkt[6], m_phase == 1 && m_pkt[6],
                 (m_phase == 1) ? m_pkt[5:3] : 3'd0, (m_phase == 1) ? m_pkt[2:0] : 3'd0,
                 m_phase == 2 && !m_pkt[6], m_phase == 2 && m_pkt[6], m_owner};
      checks++;
      if (act_vec !== exp_vec) begin
        failures++;
        $display("FAIL model_cmp t=%0t got %b expected %b", $time, act_vec, exp_vec);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  int n_xfer;

  initial begin
    rst = 1'b1;
    in_valid_1 = 0; in_valid_2 = 0;
    data_in_1 = '0; data_in_2 = '0;
    ready_slave1 = 0; ready_slave2 = 0;
    step(2);
    check("rst_in_ready_1", int'(in_ready_1), 1);
    check("rst_in_ready_2", int'(in_ready_2), 1);
    check("rst_valid", int'({valid_slave1, valid_slave2}), 0);
    check("rst_grant", int'(grant_id), 0);
    rst = 1'b0;
    chk_en = 1;

    // Single request to slave 1
    ready_slave1 = 1;
    in_valid_1 = 1; data_in_1 = 7'b0_101_011;
    step(1);
    in_valid_1 = 0;
    step(1);
    check("single_valid1", int'(valid_slave1), 1);
    check("single_addr", int'(addr_out), 5);
    check("single_value", int'(value_out), 3);
    check("single_grant", int'(grant_id), 0);
    step(1);
    check("single_hs1", int'(handshake_slave1), 1);
    check("single_valid_done", int'(valid_slave1), 0);
    step(1);
    check("single_hs1_once", int'(handshake_slave1), 0);
    check("single_empty", int'(in_ready_1), 1);

    // Contention from a fresh reset
    rst = 1; step(1); rst = 0;
    ready_slave1 = 1; ready_slave2 = 1;
    in_valid_1 = 1; data_in_1 = 7'h05;
    in_valid_2 = 1; data_in_2 = 7'h4A;
    step(1);
    in_valid_1 = 0; in_valid_2 = 0;
    step(1);
    check("cont_first_grant", int'(grant_id), 0);
    check("cont_first_valid1", int'(valid_slave1), 1);
    check("cont_first_value", int'(value_out), 5);
    step(3);
    check("cont_second_grant", int'(grant_id), 1);
    check("cont_second_valid2", int'(valid_slave2), 1);
    check("cont_second_addr", int'(addr_out), 1);
    check("cont_second_value", int'(value_out), 2);
    step(1);
    check("cont_hs2", int'(handshake_slave2), 1);
    step(1);

    // Round-robin with both queues kept full
    n_xfer = 0;
    for (int cyc = 0; cyc < 60 && n_xfer < 8; cyc++) begin
      in_valid_1 = 1; data_in_1 = 7'(cyc * 5 + 1);
      in_valid_2 = 1; data_in_2 = 7'(cyc * 3 + 64);
      step(1);
      if (valid_slave1 || valid_slave2) begin
        check("rr_grant", int'(grant_id), n_xfer % 2);
        n_xfer++;
      end
    end
    in_valid_1 = 0; in_valid_2 = 0;
    check("rr_transfers", n_xfer, 8);
    step(20);

    // Backpressure on slave 2
    ready_slave1 = 1; ready_slave2 = 0;
    in_valid_2 = 1; data_in_2 = 7'h5E;
    step(1);
    data_in_2 = 7'h61;
    step(1);
    data_in_2 = 7'h7F;
    for (int i = 0; i < 10; i++) begin
      check("bp_valid2", int'(valid_slave2), 1);
      check("bp_addr", int'(addr_out), 3);
      check("bp_value", int'(value_out), 6);
      check("bp_in_ready_2", int'(in_ready_2), 0);
      step(1);
    end
    in_valid_2 = 0; ready_slave2 = 1;
    step(1);
    check("bp_hs2", int'(handshake_slave2), 1);
    check("bp_in_ready_2_free", int'(in_ready_2), 1);
    step(2);
    check("bp_second_addr", int'(addr_out), 4);
    check("bp_second_value", int'(value_out), 1);
    check("bp_second_grant", int'(grant_id), 1);
    step(3);
    check("bp_dropped_not_issued", int'(valid_slave2), 0);

    // Ready on the wrong slave is ignored
    ready_slave1 = 0; ready_slave2 = 1;
    in_valid_1 = 1; data_in_1 = 7'h2C;
    step(1);
    in_valid_1 = 0;
    step(1);
    for (int i = 0; i < 5; i++) begin
      check("wrong_valid1", int'(valid_slave1), 1);
      check("wrong_no_hs", int'({handshake_slave1, handshake_slave2}), 0);
      step(1);
    end
    ready_slave1 = 1;
    step(1);
    check("wrong_hs1", int'(handshake_slave1), 1);
    step(1);

    // Reset while a packet is offered
    ready_slave1 = 0; ready_slave2 = 0;
    in_valid_1 = 1; data_in_1 = 7'h13;
    in_valid_2 = 1; data_in_2 = 7'h15;
    step(1);
    in_valid_1 = 0; in_valid_2 = 0;
    step(1);
    check("mid_valid1", int'(valid_slave1), 1);
    check("mid_grant", int'(grant_id), 1);
    check("mid_addr", int'(addr_out), 2);
    rst = 1; in_valid_1 = 1; data_in_1 = 7'h7F; ready_slave1 = 1;
    step(1);
    rst = 0; in_valid_1 = 0;
    check("mid_rst_valid", int'({valid_slave1, valid_slave2}), 0);
    check("mid_rst_hs", int'({handshake_slave1, handshake_slave2}), 0);
    check("mid_rst_ready", int'({in_ready_1, in_ready_2}), 3);
    check("mid_rst_grant", int'(grant_id), 0);
    step(1);
    check("mid_no_hs_after", int'(handshake_slave1), 0);
    check("mid_no_issue_after", int'(valid_slave1), 0);
    in_valid_1 = 1; data_in_1 = 7'h2B;
    step(1);
    in_valid_1 = 0;
    step(1);
    check("fresh_valid1", int'(valid_slave1), 1);
    check("fresh_addr", int'(addr_out), 5);
    check("fresh_value", int'(value_out), 3);
    step(1);
    check("fresh_hs1", int'(handshake_slave1), 1);
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
